// File: rtl/bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bus_arbiter_pkg
// Shared types and default constants for the two-master bus arbiter.
//   state_t : arbitration FSM states (IDLE, OWN, DRAIN)
//   owner_t : index of the master currently holding the bus (0 or 1)
//   DEF_MAXPENDING / DEF_HOLDMAX : default read depth and hold limit
// -----------------------------------------------------------------------------
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef logic owner_t;

    localparam int DEF_MAXPENDING = 4;
    localparam int DEF_HOLDMAX    = 8;

    // With two masters the "other" master is simply the complement.
    function automatic owner_t other_of(input owner_t o);
        return ~o;
    endfunction

endpackage

// File: rtl/read_tracker.sv
// -----------------------------------------------------------------------------
// read_tracker
// Counts reads accepted by the slave bus that have not yet returned data.
//   clk, reset : clock and asynchronous active-high reset
//   inc        : a read was accepted this cycle
//   dec        : a readValid arrived this cycle
//   count      : reads currently outstanding
//   full       : count has reached MAXPENDING
//   empty      : nothing outstanding
// A readValid seen while nothing is outstanding is a stray (for example a
// read issued before a reset) and is ignored so the count never wraps.
// -----------------------------------------------------------------------------
module read_tracker #(
    parameter  int MAXPENDING = 4,
    localparam int CW         = $clog2(MAXPENDING + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic dec_eff;
    logic inc_eff;

    assign empty   = (count == '0);
    assign full    = (count == CW'(MAXPENDING));
    assign dec_eff = dec & ~empty;
    // Never count past the limit; a return in the same cycle frees a slot.
    assign inc_eff = inc & (~full | dec_eff);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc_eff & ~dec_eff) begin
            count <= count + CW'(1);
        end else if (~inc_eff & dec_eff) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Shares one slave bus between master 0 (CPU) and master 1 (DMA-class).
// One owner at a time, round-robin on simultaneous requests, a hold limit of
// HOLDMAX accepted transactions when the other master is waiting, and the bus
// only changes hands once every read accepted from the current owner has
// returned its readValid.
//   clk, reset          : clock, asynchronous active-high reset
//   m0*/m1* inputs      : master read/write/byte-enable/address/write data
//   m0*/m1* outputs     : waitRequest, readValid, read data (broadcast)
//   sRead..sDataOut     : owner's request passed straight to the slave bus
//   sWaitRequest        : slave stall
//   sReadValid, sDataIn : read return from the slave bus
// The request path is purely combinational from the registered owner/state,
// so a granted master sees no added latency.
// -----------------------------------------------------------------------------
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int ADDRWIDTH  = 32,
    parameter int DATAWIDTH  = 32,
    parameter int MAXPENDING = DEF_MAXPENDING,
    parameter int HOLDMAX    = DEF_HOLDMAX
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   m0Read,
    input  logic                   m0Write,
    input  logic [DATAWIDTH/8-1:0] m0Bwe,
    input  logic [ADDRWIDTH-1:0]   m0Address,
    input  logic [DATAWIDTH-1:0]   m0DataOut,
    output logic                   m0WaitRequest,
    output logic                   m0ReadValid,
    output logic [DATAWIDTH-1:0]   m0DataIn,

    input  logic                   m1Read,
    input  logic                   m1Write,
    input  logic [DATAWIDTH/8-1:0] m1Bwe,
    input  logic [ADDRWIDTH-1:0]   m1Address,
    input  logic [DATAWIDTH-1:0]   m1DataOut,
    output logic                   m1WaitRequest,
    output logic                   m1ReadValid,
    output logic [DATAWIDTH-1:0]   m1DataIn,

    output logic                   sRead,
    output logic                   sWrite,
    output logic [DATAWIDTH/8-1:0] sBwe,
    output logic [ADDRWIDTH-1:0]   sAddress,
    output logic [DATAWIDTH-1:0]   sDataOut,
    input  logic                   sWaitRequest,
    input  logic                   sReadValid,
    input  logic [DATAWIDTH-1:0]   sDataIn
);

    localparam int PW = $clog2(MAXPENDING + 1);
    localparam int HW = $clog2(HOLDMAX + 1);

    state_t        state;
    owner_t        owner;
    owner_t        last_owner;
    logic [HW-1:0] hold_count;
    logic [PW-1:0] pending;
    logic          pend_full;
    logic          pend_empty;

    logic req0, req1;
    logic rd_own, wr_own;
    logic req_own, req_oth;
    logic hold_max;
    logic yield;
    logic forward;
    logic own_wait;
    logic acc_any, acc_read;
    logic rv_live;

    assign req0 = m0Read | m0Write;
    assign req1 = m1Read | m1Write;

    assign rd_own  = owner ? m1Read  : m0Read;
    assign wr_own  = owner ? m1Write : m0Write;
    assign req_own = owner ? req1 : req0;
    assign req_oth = owner ? req0 : req1;

    assign hold_max = (hold_count == HW'(HOLDMAX));
    assign yield    = req_oth & (~req_own | hold_max);
    // A new read is held back once MAXPENDING are outstanding; writes are
    // posted and never limited by the read count.
    assign forward  = (state == OWN) & ~yield & (~pend_full | ~rd_own);

    assign sRead    = forward & rd_own;
    assign sWrite   = forward & wr_own;
    assign sBwe     = owner ? m1Bwe     : m0Bwe;
    assign sAddress = owner ? m1Address : m0Address;
    assign sDataOut = owner ? m1DataOut : m0DataOut;

    assign own_wait      = forward ? sWaitRequest : 1'b1;
    assign m0WaitRequest = (owner == 1'b0) ? own_wait : 1'b1;
    assign m1WaitRequest = (owner == 1'b1) ? own_wait : 1'b1;

    // Only returns that belong to a tracked read are routed, so stray returns
    // from reads issued before a reset never reach either master.
    assign rv_live     = sReadValid & ~pend_empty;
    assign m0ReadValid = rv_live & (owner == 1'b0);
    assign m1ReadValid = rv_live & (owner == 1'b1);
    assign m0DataIn    = sDataIn;
    assign m1DataIn    = sDataIn;

    assign acc_any  = (sRead | sWrite) & ~sWaitRequest;
    assign acc_read = sRead & ~sWaitRequest;

    read_tracker #(
        .MAXPENDING (MAXPENDING)
    ) u_read_tracker (
        .clk   (clk),
        .reset (reset),
        .inc   (acc_read),
        .dec   (sReadValid),
        .count (pending),
        .full  (pend_full),
        .empty (pend_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            hold_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    hold_count <= '0;
                    if (req0 | req1) begin
                        owner <= (req0 & req1) ? other_of(last_owner) : req1;
                        state <= OWN;
                    end
                end
                OWN: begin
                    if (yield & pend_empty) begin
                        // Direct handover: the new owner is forwarded next cycle.
                        owner      <= other_of(owner);
                        last_owner <= owner;
                        hold_count <= '0;
                    end else if (yield) begin
                        state <= DRAIN;
                    end else if (~req_own & ~req_oth & pend_empty) begin
                        state      <= IDLE;
                        last_owner <= owner;
                        hold_count <= '0;
                    end else if (acc_any & ~hold_max) begin
                        hold_count <= hold_count + HW'(1);
                    end
                end
                DRAIN: begin
                    // Owner stays put so the remaining returns route to it;
                    // switch on the edge that retires the last one.
                    if (pend_empty | ((pending == PW'(1)) & sReadValid)) begin
                        owner      <= other_of(owner);
                        last_owner <= owner;
                        hold_count <= '0;
                        state      <= OWN;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
